// File: rtl/seg7_hex_reader.sv
// seg7_hex_reader
//   Recovers the hex nibbles shown on a multiplexed, active-high 7-segment bus.
//   A digit is captured only after its strobe and segment pattern stay unchanged
//   for STABLE_CYCLES samples. Captures fill a frame of NUM_DIGITS nibbles, and
//   the full frame is presented on a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   seg        segment levels {g,f,e,d,c,b,a}, 1 = lit
//   dig_sel    digit strobe, one-hot when valid; bit i = digit i
//   out_ready  consumer accepts the frame (only looked at while a frame is held)
//   out_valid  frame available
//   out_word   nibble i at bits [4i+3:4i]
//   out_err    bit i = digit i showed a pattern that is not a legal glyph
//   overrun    one-cycle pulse: a capture arrived while a frame was held and was dropped
module seg7_hex_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_word,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    overrun
);

  localparam int unsigned RUN_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t state, state_next;

  // Sampled bus and dwell tracking
  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] s_sel;
  logic [RUN_W-1:0]      run;
  logic [RUN_W-1:0]      run_next;
  logic                  fired;
  logic                  fired_next;
  logic                  sel_ok;
  logic                  same;
  logic                  fire;

  // Frame assembly
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] word_next;
  logic [NUM_DIGITS-1:0]   err_next;
  logic [4:0]              glyph;
  logic                    mask_full;

  // Glyph table: returns {err, nibble}; unknown patterns decode to 0 with err set.
  function automatic logic [4:0] decode_glyph(input logic [6:0] p);
    case (p)
      7'h3F:   return 5'h00;
      7'h06:   return 5'h01;
      7'h5B:   return 5'h02;
      7'h4F:   return 5'h03;
      7'h66:   return 5'h04;
      7'h6D:   return 5'h05;
      7'h7D:   return 5'h06;
      7'h07:   return 5'h07;
      7'h7F:   return 5'h08;
      7'h6F:   return 5'h09;
      7'h77:   return 5'h0A;
      7'h7C:   return 5'h0B;
      7'h39:   return 5'h0C;
      7'h5E:   return 5'h0D;
      7'h79:   return 5'h0E;
      7'h71:   return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) cnt++;
    end
    return cnt == 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Dwell detection. The run counter describes the samples already held in
  // s_seg/s_sel; a capture fires once, on the edge after the run first reaches
  // STABLE_CYCLES. 'fired' blocks further captures until the pair changes.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_ok   = is_onehot(dig_sel);
    same     = (seg == s_seg) && (dig_sel == s_sel);
    run_next = run;
    if (!sel_ok) begin
      run_next = '0;
    end else if (!same) begin
      run_next = RUN_W'(1);
    end else if (run != RUN_W'(STABLE_CYCLES)) begin
      run_next = run + RUN_W'(1);
    end
  end

  assign fire = (run == RUN_W'(STABLE_CYCLES)) && !fired;

  always_comb begin
    fired_next = fired;
    if (!sel_ok || !same) begin
      fired_next = 1'b0;
    end else if (fire) begin
      fired_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg <= '0;
      s_sel <= '0;
      run   <= '0;
      fired <= 1'b0;
    end else begin
      s_seg <= seg;
      s_sel <= dig_sel;
      run   <= run_next;
      fired <= fired_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot write data. s_sel is guaranteed one-hot whenever fire is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    glyph     = decode_glyph(s_seg);
    word_next = out_word;
    err_next  = out_err;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (s_sel[i]) begin
        word_next[4*i +: 4] = glyph[3:0];
        err_next[i]         = glyph[4];
      end
    end
    mask_full = &(mask | s_sel);
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (fire && mask_full) state_next = HOLD;
      HOLD:    if (out_ready)         state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    out_valid = (state == HOLD);
  end

  // Slots, mask and overrun pulse. A capture during HOLD (including the
  // handshake edge) leaves slots and mask untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask     <= '0;
      out_word <= '0;
      out_err  <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= fire && (state == HOLD);
      if (state == COLLECT) begin
        if (fire) begin
          out_word <= word_next;
          out_err  <= err_next;
          mask     <= mask | s_sel;
        end
      end else if (out_ready) begin
        mask <= '0;
      end
    end
  end

endmodule

// File: doc/seg7_hex_reader.md
Name: seg7_hex_reader

Overview:
- Reads a multiplexed, active-high 7-segment display bus and recovers the hex nibble shown on each digit.
- This is the inverse of the team's per-segment hex→7-seg decoders, so it uses the same glyph set.
- Debounces each digit strobe, assembles a full frame of NUM_DIGITS nibbles and hands it off over a valid/ready interface.
- Sits between a display-scan tap and the verification/readback logic.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 3, consecutive identical samples required before a capture (2..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
seg  input  7  segment levels {g,f,e,d,c,b,a}, 1 = lit
dig_sel  input  NUM_DIGITS  digit strobe, one-hot when valid; bit i = digit i
out_ready  input  1  consumer accepts the frame
out_valid  output  1  frame available
out_word  output  4*NUM_DIGITS  nibble i at bits [4i+3:4i]
out_err  output  NUM_DIGITS  bit i = digit i pattern was not a legal glyph
overrun  output  1  one-cycle pulse: a capture was dropped

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - Asynchronous assertion clears out_valid, out_word, out_err, overrun, the captured-slot mask, the sample registers and the run counter.
  - FSM returns to COLLECT.
  - A partial frame is discarded. Reset takes effect mid-hold or mid-frame.
- Glyph table (seg hex → nibble):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7.
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
  - Any other pattern, including 00, is illegal: nibble = 0, err bit = 1.
- Sampling:
  - seg and dig_sel are registered every edge.
  - A run counter counts consecutive identical {seg, dig_sel} samples and saturates at STABLE_CYCLES.
  - Any change in either field restarts the run at 1.
  - A dig_sel that is zero or not one-hot forces the run to 0 and can never capture.
- Capture:
  - A pair applied before edge k and held through edge k+STABLE_CYCLES-1 writes its slot at edge k+STABLE_CYCLES.
  - Exactly one capture per dwell; a new capture requires a change and a fresh run.
  - A shorter hold produces no capture.
- FSM COLLECT:
  - A capture writes the nibble and err bit for the selected digit and sets its mask bit.
  - A re-capture of an already-set digit overwrites it (latest wins).
  - When the write fills the mask, the FSM goes to HOLD and out_valid rises at that same edge.
- FSM HOLD:
  - out_valid = 1; out_word and out_err are frozen.
  - When out_valid && out_ready are both 1 at an edge, the FSM clears the mask and out_valid, then returns to COLLECT.
  - out_word and out_err keep their last values until overwritten.
- Overrun:
  - Any capture that fires while in HOLD, including on the handshake edge, is dropped.
  - overrun pulses high for exactly one cycle.
  - Slots and mask are unchanged.
- out_ready is ignored in COLLECT; no combinational path from out_ready to out_valid.

Test Plan:
- Reset, then NUM_DIGITS=4, STABLE_CYCLES=3:
  - Drive sel=0001/seg=06, 0010/5B, 0100/4F, 1000/66, each held 4 cycles.
  - Required: out_valid=1, out_word=16'h4321, out_err=0.
  - Handshake with out_ready=1 → out_valid=0 next cycle.
- Glitch filter:
  - Hold sel=0001/seg=7F for 2 edges only, then sel=0000.
  - Required: no slot write, mask unchanged.
  - Repeat with a 3-edge hold → slot0=8 written exactly 3 edges after first sample.
- Illegal glyph and overwrite:
  - Capture digit2 with seg=00 → out_err[2]=1, nibble 0.
  - Recapture digit2 with 39 → out_err[2]=0, nibble C.
  - Then fill the rest; frame reports C in digit2.
- Overrun:
  - Complete a frame, hold out_ready=0 and capture sel=0001/seg=71.
  - Required: overrun high one cycle, out_word unchanged, out_valid stays 1.
  - Release out_ready → next frame collects cleanly.
- Bad strobe:
  - dig_sel=0011 held 10 cycles with seg=3F.
  - Required: no capture, no overrun.
- Async reset:
  - Assert rst_n=0 mid-frame (2 slots filled) and mid-HOLD.
  - Required: outputs zero immediately, without a clock edge; after release a full 4-digit frame is needed before out_valid.
